// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one external memory port among
// NUM_CH requesters. One transaction is outstanding at a time; writes are
// posted, reads wait for MEM_data_ready or a bounded timeout.
//
// Handshake: a channel raises I_req with its write/size/addr/data and holds
// them until it sees its O_grant bit (one-cycle pulse, coincident with
// MEM_exec). From the following cycle it drops I_req or presents a new
// request. Requests are only sampled while idle. O_data_valid / O_error are
// one-cycle completion pulses for reads; a write completes with its grant.
module mem_arbiter #(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                     I_clk,
  input  logic                     I_reset,
  input  logic [NUM_CH-1:0]        I_req,
  input  logic [NUM_CH-1:0]        I_write,
  input  logic [2*NUM_CH-1:0]      I_size,
  input  logic [ADDR_W*NUM_CH-1:0] I_addr,
  input  logic [DATA_W*NUM_CH-1:0] I_data,
  output logic [NUM_CH-1:0]        O_grant,
  output logic [NUM_CH-1:0]        O_data_valid,
  output logic [NUM_CH-1:0]        O_error,
  output logic [DATA_W-1:0]        O_data,
  input  logic                     MEM_ready,
  input  logic [DATA_W-1:0]        MEM_data_in,
  input  logic                     MEM_data_ready,
  output logic                     MEM_exec,
  output logic                     MEM_write,
  output logic [1:0]               MEM_size,
  output logic [ADDR_W-1:0]        MEM_addr,
  output logic [DATA_W-1:0]        MEM_data_out
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   rr_q, rr_d;
  logic [CH_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [NUM_CH-1:0] grant_d, valid_d, err_d;
  logic              exec_d, mwrite_d;
  logic [1:0]        msize_d;
  logic [ADDR_W-1:0] maddr_d;
  logic [DATA_W-1:0] mdout_d, odata_d;

  logic [1:0]        size_arr [NUM_CH];
  logic [ADDR_W-1:0] addr_arr [NUM_CH];
  logic [DATA_W-1:0] data_arr [NUM_CH];

  logic              found_hi;
  logic [CH_W-1:0]   idx_hi, idx_any, win_idx;
  logic              win_found;
  logic [NUM_CH-1:0] win_oh, own_oh;

  // Split the flat per-channel buses into indexable arrays.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      size_arr[k] = I_size[2*k +: 2];
      addr_arr[k] = I_addr[ADDR_W*k +: ADDR_W];
      data_arr[k] = I_data[DATA_W*k +: DATA_W];
    end
  end

  // Round-robin pick: lowest requester at or above the pointer, else the
  // lowest requester overall (the wrap-around case).
  always_comb begin
    found_hi = 1'b0;
    idx_hi   = '0;
    idx_any  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (I_req[i]) begin
        idx_any = CH_W'(i);
        if (CH_W'(i) >= rr_q) begin
          idx_hi   = CH_W'(i);
          found_hi = 1'b1;
        end
      end
    end
    win_idx   = found_hi ? idx_hi : idx_any;
    win_found = |I_req;
    win_oh    = NUM_CH'(1) << win_idx;
    own_oh    = NUM_CH'(1) << owner_q;
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    grant_d  = '0;
    valid_d  = '0;
    err_d    = '0;
    exec_d   = 1'b0;
    odata_d  = O_data;
    mwrite_d = MEM_write;
    msize_d  = MEM_size;
    maddr_d  = MEM_addr;
    mdout_d  = MEM_data_out;
    case (state_q)
      S_IDLE: begin
        if (MEM_ready && win_found) begin
          owner_d  = win_idx;
          mwrite_d = I_write[win_idx];
          msize_d  = size_arr[win_idx];
          maddr_d  = addr_arr[win_idx];
          mdout_d  = data_arr[win_idx];
          exec_d   = 1'b1;
          grant_d  = win_oh;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        rr_d    = (owner_q == CH_LAST) ? '0 : owner_q + 1'b1;
        cnt_d   = '0;
        state_d = MEM_write ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        if (MEM_data_ready) begin
          odata_d = MEM_data_in;
          valid_d = own_oh;
          state_d = S_IDLE;
        end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          err_d   = own_oh;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset drops any in-flight transaction.
  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      state_q      <= S_IDLE;
      rr_q         <= '0;
      owner_q      <= '0;
      cnt_q        <= '0;
      O_grant      <= '0;
      O_data_valid <= '0;
      O_error      <= '0;
      O_data       <= '0;
      MEM_exec     <= 1'b0;
      MEM_write    <= 1'b0;
      MEM_size     <= '0;
      MEM_addr     <= '0;
      MEM_data_out <= '0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      O_grant      <= grant_d;
      O_data_valid <= valid_d;
      O_error      <= err_d;
      O_data       <= odata_d;
      MEM_exec     <= exec_d;
      MEM_write    <= mwrite_d;
      MEM_size     <= msize_d;
      MEM_addr     <= maddr_d;
      MEM_data_out <= mdout_d;
    end
  end

endmodule
